// File: rtl/tft_video_gen_if.sv
// Control inputs and panel-side outputs of the TFT test-pattern generator.
// The generator uses the master side; the board/bench uses the slave side.
interface tft_video_gen_if;
    logic [1:0]  mode;
    logic [15:0] solid_rgb;
    logic        box_en;
    logic        btn_left;
    logic        btn_right;
    logic        btn_up;
    logic        btn_down;
    logic        pix_ce;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;
    logic        frame_start;
    logic [9:0]  box_x;
    logic [8:0]  box_y;

    modport master (
        input  mode, solid_rgb, box_en, btn_left, btn_right, btn_up, btn_down,
        output pix_ce, hsync, vsync, de, r, g, b, frame_start, box_x, box_y
    );

    modport slave (
        output mode, solid_rgb, box_en, btn_left, btn_right, btn_up, btn_down,
        input  pix_ce, hsync, vsync, de, r, g, b, frame_start, box_x, box_y
    );
endinterface

// File: rtl/tft_video_gen.sv
// TFT-LCD timing and RGB565 test-pattern generator with a movable box overlay.
// Optional macro TFT_BTN_REPEAT_EN: a button held for 16 frames auto-repeats
// one move per frame until released.
module tft_video_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter bit SYNC_POL = 1'b0,
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 8
) (
    input logic            clk,
    input logic            rst,
    tft_video_gen_if.master tft
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  BAR_W    = 10'(H_ACTIVE / 8);
    localparam logic [9:0]  BAR_LAST = 10'(7 * (H_ACTIVE / 8));
    localparam logic [9:0]  BX_MAX   = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  BX_RST   = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  STEP_X   = 10'(STEP);
    localparam logic [10:0] BOX_W    = 11'(BOX_SIZE);
    localparam logic [8:0]  V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  VS_BEG   = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0]  VS_END   = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0]  BY_MAX   = 9'(V_ACTIVE - BOX_SIZE);
    localparam logic [8:0]  BY_RST   = 9'((V_ACTIVE - BOX_SIZE) / 2);
    localparam logic [8:0]  STEP_Y   = 9'(STEP);
    localparam logic [9:0]  BOX_H    = 10'(BOX_SIZE);

    typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

    logic [DW-1:0] div, div_nxt;
    logic          pix_ce_q;
    logic [9:0]    hcnt;
    logic [8:0]    vcnt;
    logic          at_origin, active, in_box;
    logic [1:0]    mode_q, mode_eff;
    logic [2:0]    bar;
    logic [15:0]   pat, rgb_q;
    logic          hs_q, vs_q, de_q, fs_q;
    logic [9:0]    box_x, box_x_nxt;
    logic [8:0]    box_y, box_y_nxt;
    logic [10:0]   sum_x;
    logic [9:0]    sum_y;
    logic [3:0]    btn, btn_prev, rise, trig, dir_q;   // {left, right, up, down}
    logic          mv_l, mv_r, mv_u, mv_d, latch;
    state_t        state, state_nxt;

    assign div_nxt   = (div == DIV_LAST) ? '0 : div + 1'b1;
    assign at_origin = (hcnt == 10'd0) && (vcnt == 9'd0);
    assign active    = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign in_box    = ({1'b0, hcnt} >= {1'b0, box_x}) && ({1'b0, hcnt} < {1'b0, box_x} + BOX_W) &&
                       ({1'b0, vcnt} >= {1'b0, box_y}) && ({1'b0, vcnt} < {1'b0, box_y} + BOX_H);
    // A new mode is used from the first pixel of the frame it is sampled on.
    assign mode_eff  = (pix_ce_q && at_origin) ? tft.mode : mode_q;

    // Pixel clock enable: registered so it is low during and right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div      <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            div      <= div_nxt;
            pix_ce_q <= (div_nxt == DIV_LAST);
        end
    end

    // Horizontal/vertical position counters and the frame-sampled mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt   <= '0;
            vcnt   <= '0;
            mode_q <= 2'd0;
        end else if (pix_ce_q) begin
            mode_q <= mode_eff;
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Pattern colour for the current counter position.
    always_comb begin
        bar = 3'd0;
        pat = 16'h0000;
        case (mode_eff)
            2'd0: begin
                bar = (hcnt >= BAR_LAST) ? 3'd7 : 3'(hcnt / BAR_W);
                pat = {{5{~bar[1]}}, {6{~bar[2]}}, {5{~bar[0]}}};
            end
            2'd1:    pat = (hcnt[4:0] == 5'd0 || vcnt[4:0] == 5'd0) ? 16'hFFFF : 16'h0000;
            2'd2:    pat = tft.solid_rgb;
            default: pat = {hcnt[8:4], vcnt[8:3], ~hcnt[8:4]};
        endcase
    end

    // Output registers: one pix_ce behind the counters, all mutually aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            de_q  <= 1'b0;
            rgb_q <= 16'h0000;
            fs_q  <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (pix_ce_q) begin
                hs_q  <= (hcnt >= HS_BEG && hcnt < HS_END) ? SYNC_POL : ~SYNC_POL;
                vs_q  <= (vcnt >= VS_BEG && vcnt < VS_END) ? SYNC_POL : ~SYNC_POL;
                de_q  <= active;
                rgb_q <= !active ? 16'h0000 : (tft.box_en && in_box) ? ~pat : pat;
                fs_q  <= at_origin;
            end
        end
    end

    assign btn  = {tft.btn_left, tft.btn_right, tft.btn_up, tft.btn_down};
    assign rise = btn & ~btn_prev;

`ifdef TFT_BTN_REPEAT_EN
    logic [4:0] hold_cnt;   // saturates at 16 frames held

    // Hold counter: frames with a button held, cleared on release.
    always_ff @(posedge clk) begin
        if (rst || btn == 4'b0000) hold_cnt <= 5'd0;
        else if (fs_q && !hold_cnt[4]) hold_cnt <= hold_cnt + 5'd1;
    end

    assign trig = rise | (hold_cnt[4] ? btn : 4'b0000);
`else
    assign trig = rise;
`endif

    // Button edge history.
    always_ff @(posedge clk) begin
        if (rst) btn_prev <= 4'b0000;
        else     btn_prev <= btn;
    end

    // Move FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Move FSM: arm on a button edge, apply right after the next frame start.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE:    if (|trig) begin latch = 1'b1; state_nxt = ARMED; end
            ARMED:   if (fs_q) state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Opposite directions cancel; each axis saturates at its bounds.
    assign mv_l  = dir_q[3] & ~dir_q[2];
    assign mv_r  = dir_q[2] & ~dir_q[3];
    assign mv_u  = dir_q[1] & ~dir_q[0];
    assign mv_d  = dir_q[0] & ~dir_q[1];
    assign sum_x = {1'b0, box_x} + {1'b0, STEP_X};
    assign sum_y = {1'b0, box_y} + {1'b0, STEP_Y};

    // Next box position with edge clamping.
    always_comb begin
        box_x_nxt = box_x;
        box_y_nxt = box_y;
        if (mv_r)      box_x_nxt = (sum_x > {1'b0, BX_MAX}) ? BX_MAX : sum_x[9:0];
        else if (mv_l) box_x_nxt = (box_x < STEP_X) ? 10'd0 : box_x - STEP_X;
        if (mv_d)      box_y_nxt = (sum_y > {1'b0, BY_MAX}) ? BY_MAX : sum_y[8:0];
        else if (mv_u) box_y_nxt = (box_y < STEP_Y) ? 9'd0 : box_y - STEP_Y;
    end

    // Latched direction and box position (only touched in APPLY).
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q <= 4'b0000;
            box_x <= BX_RST;
            box_y <= BY_RST;
        end else begin
            if (latch) dir_q <= trig;
            if (state == APPLY) begin
                box_x <= box_x_nxt;
                box_y <= box_y_nxt;
            end
        end
    end

    assign tft.pix_ce      = pix_ce_q;
    assign tft.hsync       = hs_q;
    assign tft.vsync       = vs_q;
    assign tft.de          = de_q;
    assign tft.r           = rgb_q[15:11];
    assign tft.g           = rgb_q[10:5];
    assign tft.b           = rgb_q[4:0];
    assign tft.frame_start = fs_q;
    assign tft.box_x       = box_x;
    assign tft.box_y       = box_y;
endmodule

// File: doc/tft_video_gen.md
Name: tft_video_gen

Overview:
Parametrised successor to the fixed 480x272 TFT-LCD test-pattern controller. It combines the pixel-clock-enable divider, the horizontal/vertical timing counters and the RGB565 pattern generator in one clock domain, with generic panel timing and selectable patterns. A button-steerable box overlay moves in configurable steps and is clamped at the screen edges. It sits between the board clock and the TFT-LCD pins.

Parameters:
CLK_DIV, 4, system clocks per pixel (>=1); pix_ce pulses once per CLK_DIV clocks
H_ACTIVE, 480, visible pixels per line
H_FP, 2, horizontal front porch (pixels)
H_SYNC, 41, hsync width (pixels)
H_BP, 2, horizontal back porch (pixels)
V_ACTIVE, 272, visible lines per frame
V_FP, 2, vertical front porch (lines)
V_SYNC, 10, vsync width (lines)
V_BP, 2, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)
BOX_SIZE, 32, overlay box side in pixels
STEP, 8, box displacement per move event (pixels)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
mode  in  2  pattern: 0 colour bars, 1 grid, 2 solid (solid_rgb), 3 gradient
solid_rgb  in  16  RGB565 colour for mode 2
box_en  in  1  enable box overlay
btn_left/btn_right/btn_up/btn_down  in  1 each  move requests, level, already debounced
pix_ce  out  1  pixel clock enable (drives opclk generation)
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable (active region)
r  out  5; g  out  6; b  out  5  pixel colour
frame_start  out  1  one-clk pulse at the pix_ce where hcnt=0, vcnt=0
box_x  out  10; box_y  out  9  current box top-left corner

Behaviour:
- Reset (clk edge with rst=1): divider, hcnt, vcnt = 0; hsync, vsync = inactive level (!SYNC_POL... i.e. high when SYNC_POL=0); de=0; r,g,b=0; pix_ce=0; frame_start=0; box_x=(H_ACTIVE-BOX_SIZE)/2, box_y=(V_ACTIVE-BOX_SIZE)/2. Reset mid-frame aborts the line with no partial output.
- Divider: counts 0..CLK_DIV-1, pix_ce=1 when the count equals CLK_DIV-1. CLK_DIV=1 means pix_ce constantly 1 after reset.
- Counters advance only on pix_ce. Line order: active, FP, SYNC, BP. H_TOTAL = sum of the four horizontal parameters. hcnt wraps H_TOTAL-1 -> 0, and vcnt increments on that wrap. vcnt wraps V_TOTAL-1 -> 0.
- Output registering: all outputs are registered and delayed by exactly one pix_ce from the counter value that produced them, so hsync, vsync, de and rgb stay mutually aligned. Sync is asserted while its counter is in the SYNC window.
- de=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE. r,g,b=0 whenever de=0.
- Patterns:
  - Colour bars: 8 equal vertical bars of width H_ACTIVE/8 in order white, yellow, cyan, green, magenta, red, blue, black; the last bar absorbs the remainder.
  - Grid: white where hcnt[4:0]==0 or vcnt[4:0]==0, else black.
  - Gradient: r=hcnt[8:4], g=vcnt[8:3], b=~hcnt[8:4].
- Box overlay: when box_en=1 and the pixel lies in [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE), the output is the bitwise inverse of the pattern colour.
- Move FSM (IDLE -> ARMED -> APPLY -> IDLE):
  - IDLE: a rising edge on any button (registered previous value) latches the direction and enters ARMED.
  - ARMED: waits for frame_start, then enters APPLY.
  - APPLY: updates the box position in one clk, then returns to IDLE.
  - The position therefore never changes mid-frame.
- Simultaneous edges: left and right cancel, as do up and down. Diagonal moves are allowed. Further edges arriving while in ARMED are ignored.
- Clamp: box_x is held in [0, H_ACTIVE-BOX_SIZE] and box_y in [0, V_ACTIVE-BOX_SIZE]. A step that would cross a bound saturates at the bound; there is no wrap.
- mode changes take effect at the next frame_start; the value is sampled into an internal register.

Optional Feature:
TFT_BTN_REPEAT_EN
- Defined: a button held high continuously for 16 frames auto-repeats one move per frame until it is released. The hold counter resets on release.
- Undefined: only rising edges move the box; a held button produces exactly one move.

Test Plan:
- Timing: CLK_DIV=4 with the defaults. Required: pix_ce period 4 clks; hsync low for 41 pix_ce every 525; vsync low for 10 lines every 286; de high for 480x272 pixels per frame; frame_start once per 150150 pix_ce.
- Colour bars: mode=0. Required at active pixels: pixel 0 -> r=31,g=63,b=31; pixel 60 -> r=31,g=63,b=0; pixel 479 -> 0,0,0. Any blanking pixel -> 0,0,0.
- Box move: box_en=1, single btn_right pulse mid-frame. Required: box_x stays 224 until the next frame_start, then becomes 232. Inverted pixels appear at x=232..263.
- Clamp: 40 btn_left pulses, one per frame. Required: box_x reaches 0 and stays 0. Simultaneous left+right pulse -> no change.
- Reset: assert rst mid-line for 1 clk. Required: next clk has hcnt=vcnt=0, rgb=0, de=0, sync inactive, box recentred to (224,120).
- Repeat (macro on): hold btn_down for 40 frames. Required: one move at the edge, then moves at frames 17..40, box_y saturating at 240. With the macro off, box_y=128.
